// File: rtl/word_sequencer.sv
// rtl/word_sequencer.sv - round-robin display-time scheduler for the seven-segment word driver
module word_sequencer #(
  parameter int         NREQ        = 4,
  parameter int         HOLD_CYCLES = 100_000_000,
  parameter logic [2:0] BLANK_WORD  = 3'd7,
  parameter int         IW          = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] word_in,
  input  logic              flush,
  output logic [NREQ-1:0]   ack,
  output logic [2:0]        word_sel,
  output logic              busy,
  output logic [IW-1:0]     active_id
);

  // Hold counter width; a single-cycle hold still needs one bit to exist.
  localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  logic [0:0]      state;
  logic [NREQ-1:0] pending;
  logic [2:0]      slot_word [NREQ];
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;

  logic            grant_found;
  logic [IW-1:0]   grant_id;
  logic [IW-1:0]   next_ptr;
  logic            hold_done;
  logic            do_grant;

  // Pick the first registered pending slot at or after rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  // Decision points: any cycle in IDLE, or the last cycle of a hold in SHOW.
  always_comb begin
    hold_done = (state == S_SHOW) && (cnt == '0);
    do_grant  = !flush && grant_found && ((state == S_IDLE) || hold_done);
    next_ptr  = IW'((int'(grant_id) + 1) % NREQ);
  end

  // Per-slot capture; a new request beats the clear from a same-cycle grant, flush beats both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_word[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (flush) begin
          pending[i] <= 1'b0;
        end else if (req[i]) begin
          pending[i]   <= 1'b1;
          slot_word[i] <= word_in[3*i +: 3];
        end else if (do_grant && (grant_id == IW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // IDLE/SHOW sequencing, display register, ack pulse and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_sel  <= BLANK_WORD;
      busy      <= 1'b0;
      ack       <= '0;
      active_id <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      ack <= '0;
      if (flush) begin
        state    <= S_IDLE;
        word_sel <= BLANK_WORD;
        busy     <= 1'b0;
        cnt      <= '0;
      end else if (do_grant) begin
        state     <= S_SHOW;
        word_sel  <= slot_word[grant_id];
        active_id <= grant_id;
        ack       <= NREQ'(1) << grant_id;
        cnt       <= CNT_LOAD;
        busy      <= 1'b1;
        rr_ptr    <= next_ptr;
      end else if (hold_done) begin
        state    <= S_IDLE;
        word_sel <= BLANK_WORD;
        busy     <= 1'b0;
      end else if (state == S_SHOW) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_sequencer.sv
// tb/tb_word_sequencer.sv - directed scoreboard bench for word_sequencer
module tb_word_sequencer;

  localparam int         NREQ  = 4;
  localparam int         HOLD  = 4;
  localparam logic [2:0] BLANK = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] word_in;
  logic        flush;
  logic [3:0]  ack;
  logic [2:0]  word_sel;
  logic        busy;
  logic [1:0]  active_id;

  word_sequencer #(
    .NREQ(NREQ),
    .HOLD_CYCLES(HOLD),
    .BLANK_WORD(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .word_in(word_in),
    .flush(flush),
    .ack(ack),
    .word_sel(word_sel),
    .busy(busy),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] word;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         show_left = 0;
  bit         showing = 1'b0;
  logic [2:0] cur_word = 3'd0;
  logic [1:0] last_id = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    show_left = 0;
    showing   = 1'b0;
  endtask

  // Cycle-level expectation of the display: grants pop the scoreboard, holds last HOLD cycles.
  task automatic monitor();
    exp_t       e;
    logic [3:0] exp_ack;
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    if (ack !== 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = sb.pop_front();
        exp_ack = 4'b0001 << e.id;
        chk("grant_ack", 32'(ack), 32'(exp_ack));
        chk("grant_word", 32'(word_sel), 32'(e.word));
        chk("grant_id", 32'(active_id), 32'(e.id));
        chk("grant_busy", 32'(busy), 32'd1);
        cur_word  = e.word;
        last_id   = e.id;
        show_left = HOLD - 1;
        showing   = 1'b1;
      end
    end else if (show_left > 0) begin
      chk("hold_word", 32'(word_sel), 32'(cur_word));
      chk("hold_busy", 32'(busy), 32'd1);
      show_left--;
    end else begin
      if (showing) chk("b2b_grant_missing", 32'(sb.size()), 32'd0);
      chk("idle_word", 32'(word_sel), 32'(BLANK));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_active_id", 32'(active_id), 32'(last_id));
      showing = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_req(input int id, input logic [2:0] w);
    req[id] = 1'b1;
    word_in[3*id +: 3] = w;
  endtask

  task automatic push(input logic [1:0] id, input logic [2:0] w);
    exp_t e;
    e.id   = id;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    last_id = 2'd0;
    chk("rst_word", 32'(word_sel), 32'(BLANK));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_active_id", 32'(active_id), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; word_in = '0; flush = 1'b0;
    @(negedge clk);

    // Single request: ack and word two cycles after req, held HOLD cycles, then blank.
    do_reset();
    set_req(2, 3'd1); push(2'd2, 3'd1);
    tick(); req = '0;
    run(8);
    chk("single_drained", 32'(sb.size()), 32'd0);

    // Round-robin order from pointer 0, back-to-back, then pointer back at 0.
    do_reset();
    set_req(0, 3'd0); set_req(1, 3'd1); set_req(3, 3'd4);
    push(2'd0, 3'd0); push(2'd1, 3'd1); push(2'd3, 3'd4);
    tick(); req = '0;
    run(14);
    set_req(0, 3'd5); set_req(1, 3'd6); set_req(2, 3'd2); set_req(3, 3'd3);
    push(2'd0, 3'd5); push(2'd1, 3'd6); push(2'd2, 3'd2); push(2'd3, 3'd3);
    tick(); req = '0;
    run(18);
    chk("rr_drained", 32'(sb.size()), 32'd0);

    // Overwrite while pending: latest word, single grant.
    do_reset();
    set_req(0, 3'd0); push(2'd0, 3'd0);
    tick(); req = '0;
    tick();
    tick();
    set_req(1, 3'd2); push(2'd1, 3'd3);
    tick();
    set_req(1, 3'd3);
    tick(); req = '0;
    run(8);
    chk("overwrite_drained", 32'(sb.size()), 32'd0);

    // Same-cycle re-request: requester 1 shown again after requester 2.
    do_reset();
    set_req(0, 3'd1); set_req(1, 3'd2); set_req(2, 3'd5);
    push(2'd0, 3'd1); push(2'd1, 3'd2); push(2'd2, 3'd5);
    tick(); req = '0;
    run(4);
    set_req(1, 3'd6); push(2'd1, 3'd6);
    tick(); req = '0;
    run(14);
    chk("rereq_drained", 32'(sb.size()), 32'd0);

    // Flush mid-SHOW with two pending and a colliding req; later request served.
    do_reset();
    set_req(0, 3'd1); push(2'd0, 3'd1);
    tick(); req = '0;
    tick();
    set_req(1, 3'd2); set_req(2, 3'd3);
    tick(); req = '0;
    flush = 1'b1; set_req(0, 3'd5);
    model_clear();
    tick();
    flush = 1'b0; req = '0;
    run(6);
    set_req(3, 3'd4); push(2'd3, 3'd4);
    tick(); req = '0;
    run(7);
    chk("flush_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the second cycle of a hold, with another request pending.
    do_reset();
    set_req(1, 3'd2); push(2'd1, 3'd2);
    tick(); req = '0;
    tick();
    set_req(3, 3'd4);
    tick(); req = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_word", 32'(word_sel), 32'(BLANK));
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_active_id", 32'(active_id), 32'd0);
    model_clear();
    last_id = 2'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(8);
    chk("arst_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
